cache_line_ctrl: RTL and testbench

- Controller for the 24-bit cache line placed in front of the 64x8 memory.
- Accepts requests for a 3-bit field at a given line base address and bit offset.
- On a tag hit, serves the field from the held line; on a miss, fills 3 consecutive memory bytes through the memory read port, then responds.
- Sits between requester logic and the 64x8 memory read port.

---
 rtl/cache_pkg.sv | 12 +
 rtl/cache_field_sel.sv | 10 +
 rtl/cache_line_ctrl.sv | 118 +++++++++++
 tb/tb_cache_line_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and geometry constants for the
// single-line cache controller and its field selector.
package cache_pkg;
    localparam int MEM_AW     = 6;
    localparam int LINE_BYTES = 3;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int FIELD_W    = 3;
    localparam int OFF_W      = 5;
    localparam logic [OFF_W-1:0] MAX_OFF = 5'd21;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_e;
endpackage

// File: rtl/cache_field_sel.sv
// cache_field_sel: extracts the FIELD_W-bit field starting at bit off_i of a cache line.
module cache_field_sel
    import cache_pkg::*;
(
    input  logic [LINE_W-1:0]  line_i,
    input  logic [OFF_W-1:0]   off_i,
    output logic [FIELD_W-1:0] field_o
);
    assign field_o = FIELD_W'(line_i >> off_i);
endmodule

// File: rtl/cache_line_ctrl.sv
// cache_line_ctrl: one 24-bit cache line in front of a 64x8 memory read port.
// Define CACHE_LINE_STATS_EN to get saturating hit/miss counters.
module cache_line_ctrl
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [MEM_AW-1:0]   req_base,
    input  logic [OFF_W-1:0]    req_off,
    input  logic                flush,
    output logic                rsp_valid,
    output logic [FIELD_W-1:0]  rsp_data,
    output logic                rsp_err,
    output logic                mem_rd,
    output logic [MEM_AW-1:0]   mem_adr,
    input  logic [7:0]          mem_data,
    output logic [7:0]          hit_cnt,
    output logic [7:0]          miss_cnt
);
    state_e              state_q, state_d;
    logic [1:0]          cnt_q;
    logic [MEM_AW-1:0]   base_q, tag_q;
    logic [OFF_W-1:0]    off_q;
    logic                err_q, valid_q, pend_q, rsp_err_q;
    logic [FIELD_W-1:0]  rsp_data_q, field;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                accept, bad_off, hit;

    assign accept  = req_valid && state_q == IDLE;
    assign bad_off = req_off > MAX_OFF;
    // a flush on the accepting edge wins, so the request sees an empty line
    assign hit     = valid_q && !flush && tag_q == req_base;

    cache_field_sel u_sel (.line_i(line_q), .off_i(off_q), .field_o(field));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (accept ? ((bad_off || hit) ? RESP : FILL) : IDLE)
                : state_q == FILL ? (cnt_q == 2'd3 ? RESP : FILL)
                : IDLE;
    end

    always_comb begin
        req_ready = state_q == IDLE;
        rsp_valid = state_q == RESP;
        mem_rd    = state_q == FILL && cnt_q != 2'd3;
        mem_adr   = mem_rd ? base_q + {4'd0, cnt_q} : '0;
        rsp_err   = rsp_valid ? err_q : rsp_err_q;
        rsp_data  = rsp_valid ? (err_q ? '0 : field) : rsp_data_q;
    end

    // read data lags its strobe by one cycle, so fill counts 1..3 capture bytes 0..2
    always_comb begin
        line_d = line_q;
        if (state_q == FILL && cnt_q != 2'd0)
            line_d = cnt_q == 2'd1 ? {line_q[23:8], mem_data}
                   : cnt_q == 2'd2 ? {line_q[23:16], mem_data, line_q[7:0]}
                   : {mem_data, line_q[15:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            base_q     <= '0;
            off_q      <= '0;
            err_q      <= 1'b0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
            line_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            cnt_q      <= state_q == FILL ? cnt_q + 2'd1 : 2'd0;
            line_q     <= line_d;
            rsp_data_q <= rsp_data;
            rsp_err_q  <= rsp_err;
            pend_q     <= state_q == FILL ? (pend_q || flush) : 1'b0;
            if (accept) begin
                base_q <= req_base;
                off_q  <= req_off;
                err_q  <= bad_off;
            end
            if (state_q == FILL && cnt_q == 2'd3) begin
                tag_q   <= base_q;
                valid_q <= 1'b1;
            end else if ((state_q == IDLE && flush) || (state_q == RESP && (pend_q || flush))) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef CACHE_LINE_STATS_EN
    logic [7:0] hit_q, miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (accept && !bad_off) begin
            if (hit && hit_q != 8'hff)   hit_q  <= hit_q + 8'd1;
            if (!hit && miss_q != 8'hff) miss_q <= miss_q + 8'd1;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cache_line_ctrl.sv
// tb_cache_line_ctrl: randomized and directed checks of cache_line_ctrl against
// a line/tag/memory model kept as plain arrays and integers.
module tb_cache_line_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_ready;
    logic [5:0] req_base = '0;
    logic [4:0] req_off = '0;
    logic       flush = 1'b0;
    logic       rsp_valid, rsp_err, mem_rd;
    logic [2:0] rsp_data;
    logic [5:0] mem_adr;
    logic [7:0] mem_data = '0;
    logic [7:0] hit_cnt, miss_cnt;

    logic [7:0] mem [64];
    int         n_chk = 0, n_bad = 0;
    bit         m_valid = 0;
    int         m_tag = 0, m_line = 0, m_hit = 0, m_miss = 0;

    cache_line_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_off(req_off), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_rd(mem_rd), .mem_adr(mem_adr), .mem_data(mem_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem_rd ? mem[mem_adr] : 8'($urandom);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt();
`ifdef CACHE_LINE_STATS_EN
        chk("hit_cnt", hit_cnt, m_hit);
        chk("miss_cnt", miss_cnt, m_miss);
`else
        chk("hit_cnt", hit_cnt, 0);
        chk("miss_cnt", miss_cnt, 0);
`endif
    endtask

    // Issues one request; caller is #1 after a posedge. fl_cyc=k raises flush during cycle k.
    task automatic do_req(input int b, input int o, input bit fl_acc, input int fl_cyc);
        bit err, hit, got;
        int lat, nrd, exp_lat, exp_d, line;
        if (fl_acc) m_valid = 0;
        err = o > 21;
        hit = !err && m_valid && m_tag == b;
        exp_lat = (err || hit) ? 1 : 5;
        line = hit ? m_line : mem[b] | (mem[(b + 1) % 64] << 8) | (mem[(b + 2) % 64] << 16);
        exp_d = err ? 0 : (line >> o) & 7;
        chk("ready", req_ready, 1);
        req_valid = 1; req_base = 6'(b); req_off = 5'(o); flush = fl_acc;
        @(posedge clk); #1;
        req_valid = 0; flush = 0;
        got = 0; lat = 0; nrd = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            if (mem_rd) begin
                chk("mem_adr", mem_adr, (b + nrd) % 64);
                nrd++;
            end
            if (rsp_valid) begin
                got = 1; lat = c;
                chk("rsp_data", rsp_data, exp_d);
                chk("rsp_err", rsp_err, err);
            end
            if (c == fl_cyc) flush = 1;
            @(posedge clk); #1;
            flush = 0;
        end
        chk("latency", lat, exp_lat);
        chk("n_mem_rd", nrd, exp_lat == 5 ? 3 : 0);
        chk("hold", {rsp_valid, rsp_err, rsp_data}, {1'b0, err, 3'(exp_d)});
        if (!err) begin
            if (hit) m_hit = m_hit < 255 ? m_hit + 1 : 255;
            else     m_miss = m_miss < 255 ? m_miss + 1 : 255;
        end
        if (!err && !hit) begin
            m_line = line; m_tag = b; m_valid = 1;
        end
        if (fl_cyc >= 1 && fl_cyc <= exp_lat) m_valid = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[10] = 8'hA5; mem[11] = 8'h3C; mem[12] = 8'h0F;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
        chk("rst_mem", {mem_rd, mem_adr}, 0);
        chk_cnt();
        rst = 0;
        @(posedge clk); #1;

        do_req(10, 4, 0, 0);
        chk("cold_field", rsp_data, 3'b010);
        do_req(10, 8, 0, 0);
        chk("hit_field", rsp_data, 3'b100);
        do_req(10, 22, 0, 0);
        do_req(10, 31, 0, 0);
        do_req(10, 21, 0, 0);
        do_req(62, 0, 0, 0);
        do_req(62, 19, 0, 0);
        do_req(20, 5, 0, 2);
        do_req(20, 5, 0, 0);
        do_req(20, 7, 0, 0);
        do_req(20, 3, 1, 0);
        flush = 1;
        @(posedge clk); #1;
        flush = 0; m_valid = 0;
        do_req(20, 0, 0, 0);
        chk_cnt();

        // reset in the middle of a fill must discard it
        req_valid = 1; req_base = 6'd40; req_off = 5'd0; flush = 1;
        @(posedge clk); #1;
        req_valid = 0; flush = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        m_valid = 0; m_hit = 0; m_miss = 0;
        chk("mid_rst", {req_ready, rsp_valid, rsp_data, rsp_err, mem_rd}, {1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        chk_cnt();
        begin
            int stray = 0;
            for (int c = 0; c < 6; c++) begin
                stray += int'(rsp_valid);
                @(posedge clk); #1;
            end
            chk("no_stray_rsp", stray, 0);
        end
        do_req(40, 0, 0, 0);

        for (int n = 0; n < 250; n++) begin
            int b;
            b = $urandom_range(0, 5);
            b = b > 3 ? 58 + b : b * 21;
            if ($urandom_range(0, 5) == 0) mem[$urandom_range(0, 63)] = 8'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            do_req(b, $urandom_range(0, 23), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0 ? $urandom_range(1, 5) : 0);
        end
        chk_cnt();

        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        m_valid = 0; m_hit = 0; m_miss = 0;
        do_req(33, 1, 0, 0);
        for (int n = 0; n < 300; n++) do_req(33, $urandom_range(0, 21), 0, 0);
        chk_cnt();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
